mnist_run_ctrl: RTL

- Sequencer for one MNIST inference run on the board.
- Takes the debounced start pulse from the key block and requests an image load into the feature buffer.
- Launches the CNN, captures the class it reports, and compares it with the expected digit set on the switches.
- Drives the match and error LEDs (active-low, board convention) and counts completed runs.

---
 rtl/mnist_run_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/mnist_run_ctrl.sv
// mnist_run_ctrl: sequencer for one MNIST inference run.
// IDLE -> LOAD (image into feature buffer) -> RUN (CNN) -> SHOW (match LED)
// -> IDLE, with LOAD/RUN watchdog into ERR. Every output is a flop; the
// output registers are loaded from the next state so they line up with
// the state they describe.
module mnist_run_ctrl #(
    parameter int SHOW_CYCLES    = 75000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CLASS_W        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CLASS_W-1:0] label_sw,
    output logic               load_req,
    input  logic               load_done,
    output logic               cnn_start,
    input  logic               cnn_done,
    input  logic [CLASS_W-1:0] cnn_class,
    output logic               busy,
    output logic [CLASS_W-1:0] result,
    output logic               match_led,
    output logic               err_led,
    output logic [7:0]         run_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SHOW,
        S_ERR
    } state_t;

    state_t             state, state_nx;
    logic [31:0]        timer;
    logic [CLASS_W-1:0] label_q;

    logic timeout, show_end, launch, finish;

    assign timeout  = (timer == 32'(TIMEOUT_CYCLES - 1));
    assign show_end = (timer == 32'(SHOW_CYCLES - 1));
    // A start is honoured only from IDLE or ERR; no queuing elsewhere.
    assign launch   = ((state == S_IDLE) || (state == S_ERR)) && start;
    assign finish   = (state == S_RUN) && cnn_done;

    // Next-state logic; a done on the timeout cycle wins over the timeout.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_ERR:   if (start) state_nx = S_LOAD;
            S_LOAD: begin
                if (load_done)    state_nx = S_RUN;
                else if (timeout) state_nx = S_ERR;
            end
            S_RUN: begin
                if (cnn_done)     state_nx = S_SHOW;
                else if (timeout) state_nx = S_ERR;
            end
            S_SHOW:  if (show_end) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register and per-state timer (cleared on every state entry).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                timer <= '0;
            else if ((state == S_LOAD) || (state == S_RUN) || (state == S_SHOW))
                timer <= timer + 32'd1;
        end
    end

    // Handshake pulses and status flags, registered from the transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_req  <= 1'b0;
            cnn_start <= 1'b0;
            busy      <= 1'b0;
            err_led   <= 1'b1;
        end else begin
            load_req  <= launch;
            cnn_start <= (state == S_LOAD) && load_done;
            busy      <= (state_nx == S_LOAD) || (state_nx == S_RUN) ||
                         (state_nx == S_SHOW);
            err_led   <= (state_nx != S_ERR);
        end
    end

    // Label latch on launch; later switch changes cannot affect the compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            label_q <= '0;
        else if (launch)
            label_q <= label_sw;
    end

    // Result capture, match LED (held through SHOW) and run counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            match_led <= 1'b1;
            run_cnt   <= '0;
        end else if (finish) begin
            result    <= cnn_class;
            match_led <= (cnn_class != label_q);
            run_cnt   <= run_cnt + 8'd1;
        end else if (state_nx != S_SHOW) begin
            match_led <= 1'b1;
        end
    end

endmodule
